// File: rtl/sa_pkg.sv
// Shared types and step-count helpers for the systolic operand path.
// Used by the operand feeder and the downstream result collector.
package sa_pkg;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DRAIN,
        DONE
    } sa_feed_state_t;

    localparam int SA_SIZE     = 4;
    localparam int RUN_STEPS   = 2 * SA_SIZE - 1;
    localparam int DRAIN_STEPS = SA_SIZE - 1;

    function automatic int run_steps(input int size);
        return 2 * size - 1;
    endfunction

    function automatic int drain_steps(input int size);
        return size - 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_operand_buffer.sv
// SIZE x SIZE operand storage for A and B with a column/row write port
// and a diagonal skew read that zero-fills outside the active window.
module sa_operand_buffer
    import sa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIZE  = 4,
    parameter int KW    = 2,
    parameter int TW    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [KW-1:0]           wr_idx,
    input  logic [SIZE*WIDTH-1:0]   wr_a_col,
    input  logic [SIZE*WIDTH-1:0]   wr_b_row,
    input  logic [TW-1:0]           t,
    output logic [SIZE*WIDTH-1:0]   rd_a,
    output logic [SIZE*WIDTH-1:0]   rd_b
);

    logic [WIDTH-1:0] a_mem [SIZE][SIZE];
    logic [WIDTH-1:0] b_mem [SIZE][SIZE];

    // Beat k lands in column k of A and row k of B; reset wipes both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    a_mem[i][j] <= '0;
                    b_mem[i][j] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int k = 0; k < SIZE; k++) begin
                if (wr_idx == KW'(k)) begin
                    for (int i = 0; i < SIZE; i++) begin
                        a_mem[i][k] <= wr_a_col[i*WIDTH +: WIDTH];
                        b_mem[k][i] <= wr_b_row[i*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Lane i carries the element whose index sum equals t, else zero.
    always_comb begin
        int tt;
        tt   = int'(t);
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < SIZE; i++) begin
            for (int k = 0; k < SIZE; k++) begin
                if (i + k == tt) begin
                    rd_a[i*WIDTH +: WIDTH] = a_mem[i][k];
                    rd_b[i*WIDTH +: WIDTH] = b_mem[k][i];
                end
            end
        end
    end

endmodule

// File: rtl/sa_operand_feeder.sv
// Loads a SIZE x SIZE operand pair beat by beat, then streams it into
// the systolic array's west and north edges with diagonal skew.
module sa_operand_feeder
    import sa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIZE  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [SIZE*WIDTH-1:0]  in_a_col,
    input  logic signed [SIZE*WIDTH-1:0]  in_b_row,
    output logic signed [SIZE*WIDTH-1:0]  op_a,
    output logic signed [SIZE*WIDTH-1:0]  op_b,
    output logic                          op_valid,
    output logic                          acc_clr,
    output logic                          done
);

    localparam int KW         = idx_width(SIZE);
    localparam int TW         = idx_width(run_steps(SIZE));
    localparam int RUN_LAST   = run_steps(SIZE) - 1;
    localparam int DRAIN_LAST = (SIZE > 1) ? drain_steps(SIZE) - 1 : 0;

    sa_feed_state_t        state;
    logic [KW-1:0]         k;
    logic [TW-1:0]         t;
    logic                  accept;
    logic [SIZE*WIDTH-1:0] rd_a;
    logic [SIZE*WIDTH-1:0] rd_b;

    assign accept = in_valid && in_ready;

    sa_operand_buffer #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE),
        .KW    (KW),
        .TW    (TW)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept),
        .wr_idx   (k),
        .wr_a_col (in_a_col),
        .wr_b_row (in_b_row),
        .t        (t),
        .rd_a     (rd_a),
        .rd_b     (rd_b)
    );

    // Operands only leave the buffer while the skew window is running.
    assign op_a = (state == RUN) ? rd_a : '0;
    assign op_b = (state == RUN) ? rd_b : '0;

    // Load/run/drain/done sequencer with registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            k        <= '0;
            t        <= '0;
            in_ready <= 1'b1;
            op_valid <= 1'b0;
            acc_clr  <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        if (k == KW'(SIZE - 1)) begin
                            state    <= RUN;
                            k        <= '0;
                            t        <= '0;
                            in_ready <= 1'b0;
                            op_valid <= 1'b1;
                            acc_clr  <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_clr <= 1'b0;
                    if (t == TW'(RUN_LAST)) begin
                        t <= '0;
                        if (SIZE == 1) begin
                            state    <= DONE;
                            op_valid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                DRAIN: begin
                    if (t == TW'(DRAIN_LAST)) begin
                        t        <= '0;
                        state    <= DONE;
                        op_valid <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                DONE: begin
                    state    <= LOAD;
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= LOAD;
                    in_ready <= 1'b1;
                    op_valid <= 1'b0;
                    acc_clr  <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Directed bench for sa_operand_feeder at SIZE=4 and SIZE=1.
// Expected skew vectors come from the matrices loaded by the bench.
module tb_sa_operand_feeder;

    localparam int W = 8;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, op_valid, acc_clr, done;
    logic [S*W-1:0] in_a_col, in_b_row, op_a, op_b;

    logic         in_valid1, in_ready1, op_valid1, acc_clr1, done1;
    logic [W-1:0] in_a1, in_b1, op_a1, op_b1;

    int errs = 0;
    int checks = 0;

    logic [W-1:0] ma [S][S];
    logic [W-1:0] mb [S][S];

    logic [S*W-1:0] cap_a3, cap_b2, cap_b3;

    sa_operand_feeder #(.WIDTH(W), .SIZE(S)) u4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a_col (in_a_col),
        .in_b_row (in_b_row),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .acc_clr  (acc_clr),
        .done     (done)
    );

    sa_operand_feeder #(.WIDTH(W), .SIZE(1)) u1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .in_a_col (in_a1),
        .in_b_row (in_b1),
        .op_a     (op_a1),
        .op_b     (op_b1),
        .op_valid (op_valid1),
        .acc_clr  (acc_clr1),
        .done     (done1)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [S*W-1:0] exp_a(input int t);
        logic [S*W-1:0] v;
        v = '0;
        for (int i = 0; i < S; i++)
            if (t - i >= 0 && t - i < S) v[i*W +: W] = ma[i][t-i];
        return v;
    endfunction

    function automatic logic [S*W-1:0] exp_b(input int t);
        logic [S*W-1:0] v;
        v = '0;
        for (int j = 0; j < S; j++)
            if (t - j >= 0 && t - j < S) v[j*W +: W] = mb[t-j][j];
        return v;
    endfunction

    task automatic load4(input bit gap, input bit hold);
        for (int k = 0; k < S; k++) begin
            if (gap) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            chk("rdy_load", in_ready, 1);
            in_valid = 1'b1;
            for (int i = 0; i < S; i++) begin
                in_a_col[i*W +: W] = ma[i][k];
                in_b_row[i*W +: W] = mb[k][i];
            end
            @(negedge clk);
        end
        if (hold) begin
            in_a_col = '1;
            in_b_row = '1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic run_check(input string tag);
        for (int c = 0; c < 3*S; c++) begin
            bit run;
            run = (c < 2*S - 1);
            chk({tag, "_a"}, op_a, run ? exp_a(c) : '0);
            chk({tag, "_b"}, op_b, run ? exp_b(c) : '0);
            chk({tag, "_vld"}, op_valid, (c < 3*S - 2) ? 1 : 0);
            chk({tag, "_clr"}, acc_clr, (c == 0) ? 1 : 0);
            chk({tag, "_done"}, done, (c == 3*S - 2) ? 1 : 0);
            chk({tag, "_rdy"}, in_ready, (c == 3*S - 1) ? 1 : 0);
            if (c == 2) cap_b2 = op_b;
            if (c == 3) begin
                cap_a3 = op_a;
                cap_b3 = op_b;
            end
            if (c == 3*S - 2) in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a_col = '0;
        in_b_row = '0;
        in_valid1 = 1'b0;
        in_a1 = '0;
        in_b1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", in_ready, 1);
        chk("rst_a", op_a, 0);
        chk("rst_b", op_b, 0);
        chk("rst_vld", op_valid, 0);
        chk("rst_clr", acc_clr, 0);
        chk("rst_done", done, 0);
        chk("rst_rdy1", in_ready1, 1);
        rst = 1'b0;
        @(negedge clk);

        // A = 1..16 row-major, B = identity, back-to-back beats
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                ma[i][j] = W'(i*S + j + 1);
                mb[i][j] = (i == j) ? 8'd1 : 8'd0;
            end
        load4(1'b0, 1'b1);
        run_check("bb");
        chk("bb_a_t3", cap_a3, {8'd13, 8'd10, 8'd7, 8'd4});

        // same data, in_valid toggling every other cycle
        load4(1'b1, 1'b0);
        run_check("gap");

        // all -128
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                ma[i][j] = 8'h80;
                mb[i][j] = 8'h80;
            end
        load4(1'b0, 1'b0);
        run_check("neg");
        chk("neg_b3_t2", cap_b2[31:24], 0);
        chk("neg_b3_t3", cap_b3[31:24], 8'h80);
        chk("neg_a_t3", cap_a3, 32'h80808080);

        // two junk beats, reset, then clean 2I / 3I load
        in_valid = 1'b1;
        in_a_col = 32'h55555555;
        in_b_row = 32'h55555555;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                ma[i][j] = (i == j) ? 8'd2 : 8'd0;
                mb[i][j] = (i == j) ? 8'd3 : 8'd0;
            end
        load4(1'b0, 1'b0);
        run_check("rst2");

        // reset in the middle of RUN at t=3
        load4(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_vld_pre", op_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_a", op_a, 0);
        chk("mid_b", op_b, 0);
        chk("mid_vld", op_valid, 0);
        chk("mid_rdy", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= done;
        end
        chk("mid_nodone", seen, 0);

        // SIZE=1: A=5, B=-7
        chk("s1_rdy0", in_ready1, 1);
        in_valid1 = 1'b1;
        in_a1 = 8'd5;
        in_b1 = 8'hF9;
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("s1_a", op_a1, 8'd5);
        chk("s1_b", op_b1, 8'hF9);
        chk("s1_clr", acc_clr1, 1);
        chk("s1_vld", op_valid1, 1);
        chk("s1_done0", done1, 0);
        chk("s1_rdy1", in_ready1, 0);
        @(negedge clk);
        chk("s1_done", done1, 1);
        chk("s1_vld_d", op_valid1, 0);
        chk("s1_a_d", op_a1, 0);
        chk("s1_rdy_d", in_ready1, 0);
        @(negedge clk);
        chk("s1_rdy2", in_ready1, 1);
        chk("s1_done2", done1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sa_operand_feeder.md
# sa_operand_feeder

Operand feeder directly upstream of the systolic array. It accepts one column of A and one row of B per handshake beat and buffers a full SIZE×SIZE operand pair. It then drives the array's west edge (one lane per row) and north edge (one lane per column) with the diagonal skew that output-stationary accumulation needs, plus the clear/valid/done controls the array and result path consume.

## Interface
- WIDTH, 8, operand element width (signed)
- SIZE, 4, array dimension; legal range 1..16
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  feeder can accept a beat
- in_a_col  in  SIZE×WIDTH signed  beat k: element i = A[i][k]
- in_b_row  in  SIZE×WIDTH signed  beat k: element j = B[k][j]
- op_a  out  SIZE×WIDTH signed  west-edge lane i, to array row i
- op_b  out  SIZE×WIDTH signed  north-edge lane j, to array column j
- op_valid  out  1  op_a/op_b meaningful (RUN or DRAIN)
- acc_clr  out  1  array accumulators clear this cycle
- done  out  1  one-cycle pulse: last operand has reached PE (SIZE-1,SIZE-1)

## Operation
- States: LOAD, RUN, DRAIN, DONE. Reset state LOAD, beat counter k=0, step counter t=0, both buffers all zero.
- LOAD:
  - in_ready=1; a beat is accepted when in_valid&&in_ready.
  - Accepted beat k writes A buffer column k and B buffer row k, then k increments.
  - On accepting beat SIZE-1: state→RUN, t←0, k←0.
  - in_valid with in_ready=0 is ignored; the source must hold data until accepted.
- RUN, t=0..2·SIZE-2:
  - op_a[i] = A[i][t-i] when 0≤t-i<SIZE, else 0.
  - op_b[j] = B[t-j][j] when 0≤t-j<SIZE, else 0.
  - op_valid=1. acc_clr=1 only at t=0.
  - After t=2·SIZE-2: state→DRAIN with t←0. If SIZE=1, state→DONE instead.
- DRAIN: SIZE-1 cycles, op_a=op_b=0, op_valid=1; then state→DONE.
- DONE: one cycle, done=1, op_valid=0, outputs 0; then state→LOAD.
- in_ready=0 in RUN/DRAIN/DONE. The buffer holds its contents until overwritten by the next load.
- No arithmetic: operands pass through unmodified and sign preserved. Zero-fill outside the skew window is signed 0.

## Timing
- All outputs are functions of registered state and buffers only; there is no combinational in_*→op_* path.
- Reset values: in_ready=1, op_a=op_b=0, op_valid=0, acc_clr=0, done=0.
- The last accepting edge is E. RUN occupies the 2·SIZE-1 cycles after E, DRAIN the following SIZE-1, and DONE the next one.
- Total from E to the done cycle: 3·SIZE-2 cycles (10 for SIZE=4). The earliest next accept is the cycle after done, so the back-to-back period is 4·SIZE-1 cycles.
- Beats may arrive with arbitrary gaps; gaps only stretch LOAD.
- rst asserted in any state, mid-load or mid-run, immediately forces LOAD, clears counters and buffers, and zeroes outputs. A partial load is discarded.

## Structure
- Package sa_pkg:
  - state enum sa_feed_state_t (LOAD, RUN, DRAIN, DONE).
  - Step-count helper constants RUN_STEPS=2·SIZE-1 and DRAIN_STEPS=SIZE-1, shared with the downstream result collector.
- One sub-module, sa_operand_buffer:
  - SIZE×SIZE storage for A and B with column/row write port, async clear.
  - Skew read: given t, returns the op_a/op_b vectors including zero-fill.
- The feeder top holds the FSM, counters and handshake.

## Test plan
- SIZE=4, A=1..16 row-major, B=identity, beats back-to-back:
  - op_a at t=3 is {A[0][3]=4, A[1][2]=7, A[2][1]=10, A[3][0]=13}.
  - acc_clr only at t=0; done exactly 10 cycles after the last accept.
- Same data with in_valid toggling every other cycle: identical op_* sequence relative to E; in_ready=0 from E+1 until after done.
- A=B=all −128 (WIDTH=8): lanes carry −128 inside the window and 0 outside; op_b[3] is nonzero only for t=3..6.
- rst pulsed after 2 beats, then a full clean load of A=2·I, B=3·I: only the new data appears, with no residue from the aborted beats.
- rst pulsed at RUN t=3: outputs 0 and in_ready=1 the same cycle; no done pulse is produced.
- SIZE=1, A=5, B=−7: one RUN cycle with op_a=5, op_b=−7, acc_clr=1; done on the next cycle; in_ready back the cycle after.
